rv32i_instr_encoder: RTL and testbench

- Encodes instruction fields into 32-bit RV32I instruction words. Covers the same opcode classes the main decoder consumes: LOAD, STORE, R-type, I-type ALU and BRANCH.
- Used by the test/boot program loader to fill instruction memory. Each encoded word is paired with an auto-incrementing byte address.
- Valid/ready stream in, 2-deep buffered valid/ready stream out.

---
 rtl/rv32i_instr_encoder_if.sv | 84 ++++++++
 rtl/rv32i_instr_encoder.sv | 225 ++++++++++++++++++++++
 tb/tb_rv32i_instr_encoder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_instr_encoder_if.sv
// ---------------------------------------------------------------------------
// rv32i_instr_encoder_if
//
// Purpose: groups the request stream and the buffered word stream of
// rv32i_instr_encoder into one bundle.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid && ready are both high. The producer holds valid and its
// payload steady until that edge. Ready may be high or low independently of
// valid. Nothing transfers on an edge where either signal is low.
//
// Signals (directions are seen from the encoder, i.e. the slave modport):
//   in_valid   in   request valid
//   in_ready   out  encoder can accept a request
//   in_class   in   3b  0=LOAD 1=STORE 2=RTYPE 3=ITYPE 4=BRANCH (5 = ECALL
//                       when built with ENC_ECALL_EN), others illegal
//   in_rd      in   5b  destination register
//   in_rs1     in   5b  source register 1
//   in_rs2     in   5b  source register 2
//   in_funct3  in   3b  funct3 field
//   in_f7b5    in   1b  instr[30] (SUB/SRA select)
//   in_imm     in   13b signed immediate
//   out_valid  out  buffered word valid
//   out_ready  in   consumer accepts the head word
//   out_instr  out  32b encoded instruction
//   out_addr   out  ADDR_W byte address of out_instr
//   err        out  one-cycle pulse: an illegal request was consumed
//
// Modports:
//   master - the request producer / word consumer (loader or bench)
//   slave  - the encoder itself
// ---------------------------------------------------------------------------
interface rv32i_instr_encoder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic              in_f7b5;
  logic [12:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;

  modport master (
    output in_valid,
    output in_class,
    output in_rd,
    output in_rs1,
    output in_rs2,
    output in_funct3,
    output in_f7b5,
    output in_imm,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_instr,
    input  out_addr,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_class,
    input  in_rd,
    input  in_rs1,
    input  in_rs2,
    input  in_funct3,
    input  in_f7b5,
    input  in_imm,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_instr,
    output out_addr,
    output err
  );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv32i_instr_encoder
//
// Purpose: turns instruction field requests into 32-bit RV32I words for the
// program loader. Each legal word is paired with an auto-incrementing byte
// address and queued in a small FIFO that feeds the output stream.
// Covered classes: LOAD, STORE, R-type ALU, I-type ALU (incl. shifts), BRANCH.
//
// Optional feature: define ENC_ECALL_EN to make in_class 5 encode ECALL
// (0x00000073). Without it, class 5 is illegal like 6 and 7.
//
// Parameters:
//   ADDR_W     width of the byte address
//   BASE_ADDR  first address handed out after reset
//   DEPTH      output buffer entries, power of two and at least 2
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  rv32i_instr_encoder_if.slave: request stream in, word stream out,
//        err pulse (see the interface file for the signal list)
//
// Behaviour notes:
//   - in_ready is a registered "not full" flag, so a pop while full does not
//     free a slot for a push in the same cycle.
//   - Illegal requests are still consumed; they raise err for one cycle,
//     push nothing and leave the address counter alone.
//   - out_instr/out_addr always show the head entry, so they hold steady
//     while the consumer stalls.
// ---------------------------------------------------------------------------
module rv32i_instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       DEPTH     = 2
) (
  input logic                  clk,
  input logic                  rst,
  rv32i_instr_encoder_if.slave bus
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = PW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [2:0] CLS_LOAD   = 3'd0;
  localparam logic [2:0] CLS_STORE  = 3'd1;
  localparam logic [2:0] CLS_RTYPE  = 3'd2;
  localparam logic [2:0] CLS_ITYPE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_ECALL  = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  // funct3 values that make an I-type ALU op a shift-immediate
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  // -------------------------------------------------------------------------
  // Request field aliases
  // -------------------------------------------------------------------------
  logic [2:0]  cls;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic        f7b5;
  logic [12:0] imm;

  assign cls  = bus.in_class;
  assign rd   = bus.in_rd;
  assign rs1  = bus.in_rs1;
  assign rs2  = bus.in_rs2;
  assign f3   = bus.in_funct3;
  assign f7b5 = bus.in_f7b5;
  assign imm  = bus.in_imm;

  // A 13-bit immediate fits the 12-bit I/S formats only when bit 12 is a
  // copy of bit 11 (pure sign extension).
  logic imm_fits12;
  assign imm_fits12 = (imm[12] == imm[11]);

  // -------------------------------------------------------------------------
  // Encoder (combinational)
  // -------------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        enc_legal;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (cls)
      CLS_LOAD: begin
        enc_word  = {imm[11:0], rs1, f3, rd, OP_LOAD};
        enc_legal = imm_fits12;
      end
      CLS_STORE: begin
        enc_word  = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
        enc_legal = imm_fits12;
      end
      CLS_RTYPE: begin
        enc_word  = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, OP_RTYPE};
        enc_legal = 1'b1;
      end
      CLS_ITYPE: begin
        // Shift-immediates carry the SRA select in bit 30 and only a 5-bit
        // shamt; the rest of the immediate is not part of the word.
        if (f3 == F3_SLLI || f3 == F3_SRXI) begin
          enc_word = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, f3, rd, OP_ITYPE};
        end else begin
          enc_word = {imm[11:0], rs1, f3, rd, OP_ITYPE};
        end
        enc_legal = imm_fits12;
      end
      CLS_BRANCH: begin
        // Branch offsets are halfword aligned; bit 0 is never encoded.
        enc_word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11],
                     OP_BRANCH};
        enc_legal = !imm[0];
      end
      CLS_ECALL: begin
`ifdef ENC_ECALL_EN
        enc_word  = ECALL_WORD;
        enc_legal = 1'b1;
`else
        enc_word  = '0;
        enc_legal = 1'b0;
`endif
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

`ifndef ENC_ECALL_EN
  // Keeps the constant referenced in builds without the ECALL feature.
  logic ecall_word_unused;
  assign ecall_word_unused = ^ECALL_WORD;
`endif

  // -------------------------------------------------------------------------
  // Output buffer state
  // -------------------------------------------------------------------------
  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [ADDR_W-1:0] addr_q;
  logic              in_ready_q;
  logic              err_q;

  logic accept;
  logic push;
  logic pop;
  logic out_valid_w;

  assign out_valid_w = (count != '0);
  assign accept      = bus.in_valid && bus.in_ready;
  assign push        = accept && enc_legal;
  assign pop         = out_valid_w && bus.out_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      addr_q     <= BASE_ADDR;
      // Buffer is empty after reset, so the stream may open on the next
      // cycle; the output gate below holds in_ready low while rst is high.
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem[i] <= '0;
        addr_mem[i]  <= '0;
      end
    end else begin
      err_q <= accept && !enc_legal;
      if (push) begin
        instr_mem[wr_ptr] <= enc_word;
        addr_mem[wr_ptr]  <= addr_q;
        wr_ptr            <= wr_ptr + PW'(1);
        // Wraps silently at the top of the address space.
        addr_q            <= addr_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count      <= count_next;
      in_ready_q <= (count_next != FULL_CNT);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_q && !rst;
  assign bus.out_valid = out_valid_w;
  assign bus.out_instr = instr_mem[rd_ptr];
  assign bus.out_addr  = addr_mem[rd_ptr];
  assign bus.err       = err_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_rv32i_instr_encoder
//
// Table of hand-encoded requests with their expected words, replayed in
// order and then at random with a randomly stalling consumer. A negedge
// monitor keeps an expected queue of {instr, addr}, checks out_valid,
// in_ready and err every cycle, and compares the head word while valid.
// Hand-written sequences cover the full-buffer stall and reset mid-stream.
// A small address width is used so the address wrap is exercised.
// ---------------------------------------------------------------------------
module tb_rv32i_instr_encoder;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 2;
  localparam logic [AW-1:0] BASE = '0;
  localparam int unsigned QW    = 32 + AW;
  localparam int NV = 16;

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [12:0] imm;
    logic        legal;
    logic [31:0] instr;
  } vec_t;

  vec_t vt [NV];

  logic clk;
  logic rst;

  rv32i_instr_encoder_if #(.ADDR_W(AW)) bus ();

  rv32i_instr_encoder #(
    .ADDR_W   (AW),
    .BASE_ADDR(BASE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [QW-1:0] exp_q [$];
  logic [AW-1:0] exp_addr = BASE;
  logic          err_exp = 1'b0;
  logic          cur_legal = 1'b0;
  logic [31:0]   cur_instr = '0;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [2:0] cls,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3,
                         input logic f7b5, input logic [12:0] imm,
                         input logic legal, input logic [31:0] instr);
    vt[i].cls   = cls;
    vt[i].rd    = rd;
    vt[i].rs1   = rs1;
    vt[i].rs2   = rs2;
    vt[i].f3    = f3;
    vt[i].f7b5  = f7b5;
    vt[i].imm   = imm;
    vt[i].legal = legal;
    vt[i].instr = instr;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    chk("in_ready", 32'(bus.in_ready),
        32'(!rst && (exp_q.size() < int'(DEPTH))));
    chk("err", 32'(bus.err), 32'(err_exp));
    if (bus.out_valid && exp_q.size() != 0) begin
      chk("out_instr", bus.out_instr, exp_q[0][QW-1:AW]);
      chk("out_addr", 32'(bus.out_addr), 32'(exp_q[0][AW-1:0]));
      if (bus.out_ready && !rst) void'(exp_q.pop_front());
    end
    if (rst) begin
      exp_q.delete();
      exp_addr = BASE;
      err_exp  = 1'b0;
    end else begin
      err_exp = bus.in_valid && bus.in_ready && !cur_legal;
      if (bus.in_valid && bus.in_ready && cur_legal) begin
        exp_q.push_back({cur_instr, exp_addr});
        exp_addr = exp_addr + AW'(4);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int idx);
    bus.in_class  = vt[idx].cls;
    bus.in_rd     = vt[idx].rd;
    bus.in_rs1    = vt[idx].rs1;
    bus.in_rs2    = vt[idx].rs2;
    bus.in_funct3 = vt[idx].f3;
    bus.in_f7b5   = vt[idx].f7b5;
    bus.in_imm    = vt[idx].imm;
    cur_legal     = vt[idx].legal;
    cur_instr     = vt[idx].instr;
    bus.in_valid  = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send(input int idx, input bit rnd);
    int waited;
    drive(idx);
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      if (waited > 50) begin
        chk("send timeout", 32'd1, 32'd0);
        break;
      end
      waited++;
      @(posedge clk);
      #1;
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    while (exp_q.size() != 0 || bus.out_valid) begin
      if (waited > 50) begin
        chk("drain timeout", 32'd1, 32'd0);
        break;
      end
      waited++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    //       idx cls   rd  rs1 rs2 f3    f7b5 imm       legal instr
    set_vec(0,  3'd0, 5,  2,  0,  3'd2, 0, 13'd8,     1, 32'h00812283);
    set_vec(1,  3'd2, 3,  1,  2,  3'd0, 0, 13'd0,     1, 32'h002081B3);
    set_vec(2,  3'd2, 3,  1,  2,  3'd0, 1, 13'd0,     1, 32'h402081B3);
    set_vec(3,  3'd1, 0,  2,  6,  3'd2, 0, 13'd12,    1, 32'h00612623);
    set_vec(4,  3'd4, 0,  1,  2,  3'd0, 0, 13'h1FF8,  1, 32'hFE208CE3);
    set_vec(5,  3'd3, 1,  0,  0,  3'd0, 0, 13'h1FFF,  1, 32'hFFF00093);
    set_vec(6,  3'd3, 2,  2,  0,  3'd5, 1, 13'd3,     1, 32'h40315113);
    set_vec(7,  3'd0, 1,  0,  0,  3'd2, 0, 13'h1800,  1, 32'h80002083);
    set_vec(8,  3'd4, 0,  0,  0,  3'd1, 0, 13'h0FFE,  1, 32'h7E001FE3);
    set_vec(9,  3'd7, 1,  1,  1,  3'd0, 0, 13'd0,     0, 32'h0);
    set_vec(10, 3'd4, 0,  1,  2,  3'd0, 0, 13'd3,     0, 32'h0);
    set_vec(11, 3'd0, 1,  0,  0,  3'd2, 0, 13'h0800,  0, 32'h0);
    set_vec(12, 3'd1, 0,  2,  6,  3'd2, 0, 13'h1000,  0, 32'h0);
`ifdef ENC_ECALL_EN
    set_vec(13, 3'd5, 7,  7,  7,  3'd7, 1, 13'h1234,  1, 32'h00000073);
`else
    set_vec(13, 3'd5, 7,  7,  7,  3'd7, 1, 13'h1234,  0, 32'h0);
`endif
    set_vec(14, 3'd3, 1,  1,  0,  3'd1, 0, 13'h0025,  1, 32'h00509093);
    set_vec(15, 3'd6, 0,  0,  0,  3'd0, 0, 13'd0,     0, 32'h0);

    bus.in_valid  = 1'b0;
    bus.in_class  = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_funct3 = '0;
    bus.in_f7b5   = 1'b0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset err", 32'(bus.err), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset out_instr", bus.out_instr, 32'd0);
    chk("reset out_addr", 32'(bus.out_addr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // First word: visible one cycle after accept at BASE
    send(0, 0);
    @(negedge clk);
    chk("first word instr", bus.out_instr, 32'h00812283);
    chk("first word addr", 32'(bus.out_addr), 32'(BASE));
    @(posedge clk);
    #1;

    // Whole table in order (includes illegal pair class 7 / BRANCH imm=3)
    for (int i = 0; i < NV; i++) send(i, 0);
    wait_drain();

    // Full buffer stall: two accepted, third held until after first pop
    bus.out_ready = 1'b0;
    send(0, 0);
    send(3, 0);
    drive(4);
    repeat (3) begin
      @(negedge clk);
      chk("stall in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall head", bus.out_instr, 32'h00812283);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("held until pop", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("ready after pop", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_drain();

    // Reset with two words buffered
    bus.out_ready = 1'b0;
    send(1, 0);
    send(2, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid reset out_instr", bus.out_instr, 32'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(5, 0);
    @(negedge clk);
    chk("post reset addr", 32'(bus.out_addr), 32'(BASE));
    chk("post reset instr", bus.out_instr, 32'hFFF00093);
    @(posedge clk);
    #1;
    wait_drain();

    // Random mix with a stalling consumer; address wraps several times
    for (int k = 0; k < 60; k++) send(int'($urandom_range(0, NV - 1)), 1);
    wait_drain();
    chk("final queue empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global safety bound
  initial begin
    #200000;
    $display("FAIL global timeout at %0t", $time);
    $fatal(1);
  end

endmodule
